// File: rtl/udp_tx_arbiter.sv
// ---------------------------------------------------------------------------
// udp_tx_arbiter
//
// Shares one UDP transmitter between NUM_REQ requesters. A round-robin
// arbiter picks a winner in IDLE, captures its payload and addressing, fires
// a single-cycle send strobe, then follows the transmitter's ready line
// through busy and back to idle. Each requester sees an ack when its payload
// is captured, a done when its frame has gone out, or an err when the
// transmitter never went busy after the strobe.
//
// Ports
//   clk          system clock
//   reset        synchronous reset, active-low
//   req          per-requester level request, held until ack
//   req_data     flattened payloads, requester i at [i*DATA_BYTES*8 +: DATA_BYTES*8]
//   req_ip_info  per-requester addressing
//   ack          one-cycle pulse: request accepted, payload captured
//   done         one-cycle pulse: frame transmission finished
//   err          one-cycle pulse: transmitter never went busy
//   tx_data      payload presented to the transmitter
//   tx_ip_info   addressing presented to the transmitter
//   tx_send      one-cycle send strobe
//   tx_ready     transmitter idle indicator
//   busy         high whenever the arbiter is not idle
//   grant_id     index of the current or most recent grant
// ---------------------------------------------------------------------------
package udp_tx_arbiter_pkg;

   typedef struct packed {
      logic [31:0] dst_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
   } IPInfo;

endpackage

module udp_tx_arbiter
   import udp_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int DATA_BYTES    = 8,
   parameter int START_TIMEOUT = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*DATA_BYTES*8-1:0] req_data,
   input  IPInfo                           req_ip_info [NUM_REQ],
   output logic [NUM_REQ-1:0]              ack,
   output logic [NUM_REQ-1:0]              done,
   output logic [NUM_REQ-1:0]              err,
   output logic [DATA_BYTES*8-1:0]         tx_data,
   output IPInfo                           tx_ip_info,
   output logic                            tx_send,
   input  logic                            tx_ready,
   output logic                            busy,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

   localparam int DW    = DATA_BYTES * 8;
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int SUM_W = ID_W + 1;
   localparam int CNT_W = $clog2(START_TIMEOUT);

   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t            state, state_next;
   logic [ID_W-1:0]   rr_ptr, rr_ptr_next;
   logic [CNT_W-1:0]  cnt, cnt_next;

   logic              win_valid;
   logic [ID_W-1:0]   winner;
   logic [SUM_W-1:0]  scan_sum;
   logic [ID_W-1:0]   scan_id;
   logic [ID_W-1:0]   grant_succ;
   logic [DW-1:0]     req_slice [NUM_REQ];

   logic [NUM_REQ-1:0] ack_next, done_next, err_next;
   logic [DW-1:0]      tx_data_next;
   IPInfo              tx_ip_info_next;
   logic               tx_send_next;
   logic               busy_next;
   logic [ID_W-1:0]    grant_id_next;

   // Unflatten the payload bus so the winner can be selected by index.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_slice[i] = req_data[i*DW +: DW];
      end
   end

   // Round-robin search: first asserted request starting at rr_ptr, wrapping
   // modulo NUM_REQ (which need not be a power of two).
   // NOTE: every variable written in a combinational block gets a default at
   // the top, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      win_valid = 1'b0;
      winner    = '0;
      scan_sum  = '0;
      scan_id   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_sum = {1'b0, rr_ptr} + SUM_W'(i);
         if (scan_sum >= SUM_W'(NUM_REQ)) begin
            scan_sum = scan_sum - SUM_W'(NUM_REQ);
         end
         scan_id = scan_sum[ID_W-1:0];
         if (!win_valid && req[scan_id]) begin
            win_valid = 1'b1;
            winner    = scan_id;
         end
      end
   end

   // Pointer value that puts the just-served requester at lowest priority.
   assign grant_succ = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            // A transmitter still busy (e.g. from before a reset) is waited out.
            if (tx_ready && win_valid) state_next = LAUNCH;
         end
         LAUNCH: begin
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!tx_ready)             state_next = WAIT_DONE;
            else if (cnt == CNT_LAST)  state_next = IDLE;
         end
         WAIT_DONE: begin
            if (tx_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath.
   always_comb begin
      ack_next        = '0;
      done_next       = '0;
      err_next        = '0;
      tx_send_next    = 1'b0;
      busy_next       = (state_next != IDLE);
      grant_id_next   = grant_id;
      tx_data_next    = tx_data;
      tx_ip_info_next = tx_ip_info;
      rr_ptr_next     = rr_ptr;
      cnt_next        = cnt;
      case (state)
         IDLE: begin
            if (tx_ready && win_valid) begin
               grant_id_next    = winner;
               tx_data_next     = req_slice[winner];
               tx_ip_info_next  = req_ip_info[winner];
               ack_next[winner] = 1'b1;
            end
         end
         LAUNCH: begin
            // Payload was captured on the grant edge, so it has been stable
            // for a full cycle when the strobe rises.
            tx_send_next = 1'b1;
            cnt_next     = '0;
         end
         WAIT_BUSY: begin
            if (tx_ready) begin
               if (cnt == CNT_LAST) begin
                  err_next[grant_id] = 1'b1;
                  rr_ptr_next        = grant_succ;
                  cnt_next           = '0;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
         end
         WAIT_DONE: begin
            if (tx_ready) begin
               done_next[grant_id] = 1'b1;
               rr_ptr_next         = grant_succ;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and datapath. Reset abandons any frame silently.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ack        <= '0;
         done       <= '0;
         err        <= '0;
         tx_send    <= 1'b0;
         busy       <= 1'b0;
         grant_id   <= '0;
         tx_data    <= '0;
         tx_ip_info <= '0;
         rr_ptr     <= '0;
         cnt        <= '0;
      end else begin
         ack        <= ack_next;
         done       <= done_next;
         err        <= err_next;
         tx_send    <= tx_send_next;
         busy       <= busy_next;
         grant_id   <= grant_id_next;
         tx_data    <= tx_data_next;
         tx_ip_info <= tx_ip_info_next;
         rr_ptr     <= rr_ptr_next;
         cnt        <= cnt_next;
      end
   end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_udp_tx_arbiter
//
// Directed bench for udp_tx_arbiter. Stimulus pushes the expected ack / done
// / err events into a scoreboard queue; an independent monitor pops and
// compares whenever the DUT pulses one of them, and also checks strobe
// timing, captured payload, frame stability and start-timeout latency.
// A small transmitter model drives tx_ready automatically, or the stimulus
// drives it directly for the corner cases.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_udp_tx_arbiter;
   import udp_tx_arbiter_pkg::*;

   localparam int NUM_REQ       = 4;
   localparam int DATA_BYTES    = 8;
   localparam int START_TIMEOUT = 16;
   localparam int DW            = DATA_BYTES * 8;
   localparam int ID_W          = 2;

   localparam int K_ACK  = 0;
   localparam int K_DONE = 1;
   localparam int K_ERR  = 2;

   typedef struct {
      int kind;
      int id;
   } exp_t;

   logic                       clk = 1'b0;
   logic                       reset;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*DW-1:0]      req_data;
   IPInfo                      req_ip_info [NUM_REQ];
   logic [NUM_REQ-1:0]         ack, done, err;
   logic [DW-1:0]              tx_data;
   IPInfo                      tx_ip_info;
   logic                       tx_send;
   logic                       tx_ready;
   logic                       busy;
   logic [ID_W-1:0]            grant_id;

   // Transmitter model control.
   logic auto_mode    = 1'b1;
   logic model_ready;
   logic manual_ready = 1'b1;
   int   busy_len     = 20;
   assign tx_ready = auto_mode ? model_ready : manual_ready;

   logic [DW-1:0] data_tbl [NUM_REQ];
   IPInfo         ip_tbl   [NUM_REQ];

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   udp_tx_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .DATA_BYTES   (DATA_BYTES),
      .START_TIMEOUT(START_TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_data   (req_data),
      .req_ip_info(req_ip_info),
      .ack        (ack),
      .done       (done),
      .err        (err),
      .tx_data    (tx_data),
      .tx_ip_info (tx_ip_info),
      .tx_send    (tx_send),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .grant_id   (grant_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void expect_ev(input int kind, input int id);
      exp_t e;
      e.kind = kind;
      e.id   = id;
      sb.push_back(e);
   endfunction

   // Bounded wait for a given event bit; an expired budget is a failure.
   task automatic wait_for(input int kind, input int id, input int budget);
      logic [3*NUM_REQ-1:0] v;
      int n   = 0;
      bit hit = 1'b0;
      while (!hit && n < budget) begin
         @(negedge clk);
         n++;
         v   = {err, done, ack};
         hit = v[kind*NUM_REQ + id];
      end
      if (!hit) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_event kind=%0d id=%0d: not seen within %0d cycles", kind, id, budget);
      end
   endtask

   // Transmitter model: goes busy two cycles after the strobe, stays busy
   // busy_len cycles, then returns to idle.
   initial begin : responder
      model_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (auto_mode && tx_send) begin
            repeat (2) @(posedge clk);
            #1 model_ready = 1'b0;
            repeat (busy_len) @(posedge clk);
            #1 model_ready = 1'b1;
         end
      end
   end

   // Monitor / scoreboard checker.
   initial begin : monitor
      exp_t                 e;
      int                   cyc        = 0;
      int                   send_cyc   = 0;
      int                   cur_id     = 0;
      logic [NUM_REQ-1:0]   prev_ack   = '0;
      logic                 prev_send  = 1'b0;
      logic                 prev_busy  = 1'b0;
      logic                 data_moved = 1'b0;
      logic [DW-1:0]        prev_data  = '0;
      IPInfo                prev_ip    = '0;
      logic [ID_W-1:0]      prev_gid   = '0;
      logic [3*NUM_REQ-1:0] exp_vec;
      forever begin
         @(negedge clk);
         cyc++;
         if (busy && prev_busy &&
             (tx_data !== prev_data || tx_ip_info !== prev_ip || grant_id !== prev_gid)) begin
            data_moved = 1'b1;
         end
         if (tx_send === 1'b1) begin
            check("send_one_cycle_after_ack", {prev_ack != '0, prev_send}, 2'b10);
            check("send_tx_data", tx_data, data_tbl[cur_id]);
            send_cyc = cyc;
         end
         if (|{ack, done, err}) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_event: ack=%b done=%b err=%b with empty queue", ack, done, err);
            end else begin
               e       = sb.pop_front();
               exp_vec = (3*NUM_REQ)'(1) << (e.kind*NUM_REQ + e.id);
               check("event_vector", {err, done, ack}, exp_vec);
               if (e.kind == K_ACK) begin
                  check("ack_grant_id", grant_id, e.id);
                  check("ack_tx_data", tx_data, data_tbl[e.id]);
                  check("ack_tx_ip_info", tx_ip_info, ip_tbl[e.id]);
                  check("ack_busy", busy, 1);
                  cur_id     = e.id;
                  data_moved = 1'b0;
               end else begin
                  check("frame_stable", data_moved, 0);
                  check("end_busy_low", busy, 0);
                  if (e.kind == K_ERR) begin
                     check("err_latency", cyc - send_cyc, START_TIMEOUT);
                  end
               end
            end
         end
         prev_ack  = ack;
         prev_send = tx_send;
         prev_busy = busy;
         prev_data = tx_data;
         prev_ip   = tx_ip_info;
         prev_gid  = grant_id;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bit saw_ack;
      data_tbl[0] = 64'h0123_4567_89AB_CDEF;
      data_tbl[1] = 64'hF055_7248_1160_0CF0;
      data_tbl[2] = 64'hDEAD_BEEF_CAFE_F00D;
      data_tbl[3] = 64'h5A5A_A5A5_3C3C_C3C3;
      for (int i = 0; i < NUM_REQ; i++) begin
         ip_tbl[i].dst_ip   = 32'hC0A8_0100 + 32'(i);
         ip_tbl[i].src_port = 16'h1000 + 16'(i);
         ip_tbl[i].dst_port = 16'h2000 + 16'(i * 3);
         req_ip_info[i]     = ip_tbl[i];
         req_data[i*DW +: DW] = data_tbl[i];
      end
      req   = '0;
      reset = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_ack", ack, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_tx_send", tx_send, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_ip_info", tx_ip_info, 0);
      reset = 1'b1;
      @(negedge clk);

      // Single request from requester 1.
      busy_len = 20;
      expect_ev(K_ACK, 1);
      expect_ev(K_DONE, 1);
      req = 4'b0010;
      @(negedge clk);
      check("single_ack_latency", ack, 4'b0010);
      req = '0;
      wait_for(K_DONE, 1, 60);
      check("single_grant_held", grant_id, 1);
      @(negedge clk);
      check("single_idle_busy", busy, 0);

      // Round-robin skip: pointer is at 2, so 0 wins over 1.
      busy_len = 5;
      expect_ev(K_ACK, 0);
      expect_ev(K_DONE, 0);
      expect_ev(K_ACK, 1);
      expect_ev(K_DONE, 1);
      req = 4'b0011;
      @(negedge clk);
      check("rr_skip_first", ack, 4'b0001);
      req = 4'b0010;
      wait_for(K_DONE, 0, 40);
      wait_for(K_ACK, 1, 5);
      req = '0;
      wait_for(K_DONE, 1, 40);

      // Serve requester 3 so the pointer wraps to 0.
      expect_ev(K_ACK, 3);
      expect_ev(K_DONE, 3);
      req = 4'b1000;
      @(negedge clk);
      check("wrap_ack", ack, 4'b1000);
      req = '0;
      wait_for(K_DONE, 3, 40);

      // Full contention from pointer 0: 0,1,2,3,0.
      busy_len = 10;
      for (int k = 0; k < 5; k++) begin
         expect_ev(K_ACK, k % NUM_REQ);
         expect_ev(K_DONE, k % NUM_REQ);
      end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_for(K_ACK, k % NUM_REQ, 60);
         if (k == 4) req = '0;
         wait_for(K_DONE, k % NUM_REQ, 60);
      end
      @(negedge clk);

      // Start timeout: transmitter never goes busy. Pointer at 1, so 2 wins.
      auto_mode    = 1'b0;
      manual_ready = 1'b1;
      expect_ev(K_ACK, 2);
      expect_ev(K_ERR, 2);
      req = 4'b0100;
      @(negedge clk);
      check("timeout_ack", ack, 4'b0100);
      req = '0;
      wait_for(K_ERR, 2, 40);
      // Request present on the err cycle is granted on the very next edge.
      expect_ev(K_ACK, 0);
      req = 4'b0001;
      @(negedge clk);
      check("grant_after_err", ack, 4'b0001);
      req = '0;

      // Reset mid-frame while in WAIT_DONE.
      repeat (2) @(negedge clk);
      manual_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_frame_busy", busy, 1);
      reset = 1'b0;
      req   = 4'b0010;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_tx_send", tx_send, 0);
      check("midrst_grant_id", grant_id, 0);
      check("midrst_tx_data", tx_data, 0);
      check("midrst_pulses", {err, done, ack}, 0);
      reset   = 1'b1;
      saw_ack = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (ack != '0) saw_ack = 1'b1;
      end
      check("midrst_no_grant_while_tx_busy", saw_ack, 0);
      busy_len = 8;
      expect_ev(K_ACK, 1);
      expect_ev(K_DONE, 1);
      auto_mode = 1'b1;
      @(negedge clk);
      check("midrst_grant_on_ready", ack, 4'b0010);
      req = '0;
      wait_for(K_DONE, 1, 40);

      // Start blocked by a busy transmitter. Pointer at 2, requester 0 wins.
      auto_mode    = 1'b0;
      manual_ready = 1'b0;
      req          = 4'b0001;
      saw_ack      = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (ack != '0) saw_ack = 1'b1;
      end
      check("blocked_no_ack", saw_ack, 0);
      expect_ev(K_ACK, 0);
      expect_ev(K_ERR, 0);
      manual_ready = 1'b1;
      @(negedge clk);
      check("blocked_ack_on_ready", ack, 4'b0001);
      req = '0;
      wait_for(K_ERR, 0, 40);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares a single ethernet_udp_transmit instance between NUM_REQ independent requesters, for example a UART command path and periodic status senders.
- Uses round-robin arbitration and latches the winner's payload and IPInfo.
- Issues the one-cycle send strobe to the transmitter, then tracks its ready signal through busy and back to idle.
- Reports per-requester acknowledge, completion and start-timeout error.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_BYTES, 8, payload width in bytes; must match the transmitter's DATA_BYTES.
- START_TIMEOUT, 16, number of cycles tx_ready may remain high after tx_send before the launch is declared failed; must be ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- req  in  NUM_REQ  level request per requester; must be held until ack.
- req_data  in  NUM_REQ*DATA_BYTES*8  flattened payloads; requester i occupies [i*DATA_BYTES*8 +: DATA_BYTES*8].
- req_ip_info  in  NUM_REQ x IPInfo  unpacked array of per-requester addressing.
- ack  out  NUM_REQ  one-cycle pulse: request accepted and payload captured.
- done  out  NUM_REQ  one-cycle pulse: frame transmission finished.
- err  out  NUM_REQ  one-cycle pulse: transmitter never went busy.
- tx_data  out  DATA_BYTES*8  payload to the transmitter.
- tx_ip_info  out  IPInfo  addressing to the transmitter.
- tx_send  out  1  send strobe; transmitter acts on its rising edge.
- tx_ready  in  1  transmitter idle indicator.
- busy  out  1  high whenever state ≠ IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grant.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a clk edge):
  - state=IDLE, rr_ptr=0, timeout counter=0.
  - ack, done, err, tx_send, busy, grant_id, tx_data and tx_ip_info all go to 0.
- Reset mid-frame: state is abandoned with no done or err pulse. After release, IDLE does not grant until tx_ready==1, so a transmitter still busy from before reset is waited out.
- IDLE:
  - Grants when tx_ready==1 and |req.
  - Winner is the first asserted req scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - On that edge: latch req_data slice and req_ip_info into tx_data/tx_ip_info; grant_id=winner; ack[winner]=1; busy=1; go to LAUNCH.
- LAUNCH:
  - tx_send=1 for exactly one cycle; ack returns to 0.
  - tx_data has been stable for ≥1 cycle before tx_send rises.
  - Go to WAIT_BUSY, counter=0.
- WAIT_BUSY:
  - tx_send=0.
  - If tx_ready==0, go to WAIT_DONE.
  - Otherwise counter++. When counter reaches START_TIMEOUT-1 with tx_ready still 1: err[grant_id]=1 for one cycle, rr_ptr=grant_id+1 mod NUM_REQ, go to IDLE.
- WAIT_DONE:
  - Waits indefinitely for tx_ready==1.
  - Then done[grant_id]=1 for one cycle, rr_ptr=grant_id+1 mod NUM_REQ, go to IDLE.
- tx_data, tx_ip_info and grant_id hold their values until the next grant. They never change while busy.
- Latency:
  - req sampled at edge E0 → ack high after E0.
  - tx_send high after E1.
  - tx_send low after E2.
  - A fresh grant is possible no earlier than the edge after done/err.
- At most one of ack, done or err is high in any cycle, and at most one bit of each vector is high.
- A req dropped before it is sampled in IDLE is simply not served. A req changed while another requester is in flight is ignored until IDLE.
- A requester holding req after done is re-arbitrated with lowest priority, because rr_ptr has advanced past it.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Simultaneous requests are resolved purely by rr_ptr order; with full contention every requester is served once per NUM_REQ frames.
- A tx_ready glitch high during WAIT_BUSY has no effect other than the count continuing.

Test Plan:
- Reset then single request: reset=0 for 3 cycles → all outputs 0. Release, req=4'b0010 with payload 64'hF055_7248_1160_0CF0, tx_ready model drops 2 cycles after send and rises 20 cycles later → ack[1] after E0, tx_send one cycle after ack, tx_data equals payload, done[1] once, grant_id=1, busy low afterwards.
- Full contention: req=4'b1111 held, tx_ready model busy 10 cycles per frame → grants in order 0,1,2,3,0. Each ack and done appears exactly once per frame; tx_data never changes while busy.
- Round-robin skip: rr_ptr=2 after serving 1; req=4'b0011 → requester 0 granted before 1. Wrap from 3→0 verified.
- Start timeout: tx_ready held 1 permanently, START_TIMEOUT=16 → err[g] asserted exactly 16 cycles after the tx_send cycle, no done, next grant possible on the following cycle.
- Reset mid-frame: assert reset during WAIT_DONE with tx_ready=0 → outputs 0 next cycle. After release with req pending, no ack until tx_ready returns to 1.
- Start blocked by busy transmitter: req=4'b0001 while tx_ready=0 → no ack. Raise tx_ready → ack[0] on the next edge.
